// File: rtl/final2_soc_otg_hpi_pkg.sv
// Shared definitions for the OTG HPI bus bridge.
// Holds the bridge state encoding, the four HPI register select codes and
// the default phase lengths, plus a helper that sizes the phase counter.
package final2_soc_otg_hpi_pkg;

    // Bridge FSM states: one HPI cycle walks SETUP -> STROBE -> HOLD -> RECOVER.
    typedef enum logic [2:0] {
        HPI_IDLE    = 3'd0,
        HPI_SETUP   = 3'd1,
        HPI_STROBE  = 3'd2,
        HPI_HOLD    = 3'd3,
        HPI_RECOVER = 3'd4
    } hpi_state_t;

    // HPI register selects as driven onto otg_hpi_addr.
    localparam logic [1:0] HPI_REG_DATA    = 2'd0;
    localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

    // Default phase lengths in clock cycles.
    localparam int DEF_SETUP_CYC   = 1;
    localparam int DEF_STROBE_CYC  = 4;
    localparam int DEF_HOLD_CYC    = 1;
    localparam int DEF_RECOVER_CYC = 2;

    // The counter is loaded with (phase length - 1), so it only has to hold
    // values below the longest phase; never narrower than one bit.
    function automatic int hpiCntWidth(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/final2_soc_otg_hpi_bridge.sv
// Avalon-MM slave that turns one read or write into a fully timed
// CY7C67200 HPI bus cycle (setup, strobe, hold, recovery), stalling the
// master with waitrequest until the HPI cycle reaches its last HOLD cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address[1:0]          HPI register select (DATA/MAILBOX/ADDRESS/STATUS)
//   chipselect, read_n,   Avalon access request (read_n/write_n active low,
//   write_n, writedata    both low counts as a write)
//   readdata[15:0]        registered read data, valid in the ack cycle
//   waitrequest           Avalon stall, low for exactly one cycle per transfer
//   otg_hpi_addr/cs_n/    registered HPI address, chip select and strobes
//   r_n/w_n
//   otg_hpi_data_out/oe   registered pad drive data and output enable
//   otg_hpi_data_in       pad data sampled on the last read strobe cycle
module final2_soc_otg_hpi_bridge
    import final2_soc_otg_hpi_pkg::*;
#(
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int STROBE_CYC  = DEF_STROBE_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int RECOVER_CYC = DEF_RECOVER_CYC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  otg_hpi_addr,
    output logic        otg_hpi_cs_n,
    output logic        otg_hpi_r_n,
    output logic        otg_hpi_w_n,
    output logic [15:0] otg_hpi_data_out,
    output logic        otg_hpi_data_oe,
    input  logic [15:0] otg_hpi_data_in
);

    localparam int CNT_W = hpiCntWidth(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVER_CYC);

    hpi_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               isWrite_q, isWrite_d;
    logic [1:0]         addr_q, addr_d;
    logic [15:0]        dataOut_q, dataOut_d;
    logic [15:0]        readData_q, readData_d;
    logic               csN_q, csN_d;
    logic               rdN_q, rdN_d;
    logic               wrN_q, wrN_d;
    logic               oe_q, oe_d;
    logic               req;
    logic               busNext;

    assign req = chipselect & (~read_n | ~write_n);

    // The ack is the last HOLD cycle; anything else with a request pending
    // (including RECOVER) stalls the master.
    assign waitrequest = req & ~((state_q == HPI_HOLD) && (cnt_q == '0));

    // Next-state logic: a single down-counter times every phase and is
    // reloaded with (length - 1) whenever a phase is entered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        isWrite_d  = isWrite_q;
        addr_d     = addr_q;
        dataOut_d  = dataOut_q;
        readData_d = readData_q;
        unique case (state_q)
            HPI_IDLE: begin
                if (req) begin
                    state_d   = HPI_SETUP;
                    cnt_d     = CNT_W'(SETUP_CYC - 1);
                    isWrite_d = ~write_n;
                    addr_d    = address;
                    dataOut_d = writedata;
                end
            end
            HPI_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = HPI_STROBE;
                    cnt_d   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HPI_STROBE: begin
                if (cnt_q == '0) begin
                    // Sample the pad at the end of the strobe so the data has
                    // had the full strobe width to settle.
                    if (!isWrite_q) begin
                        readData_d = otg_hpi_data_in;
                    end
                    state_d = HPI_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HPI_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = HPI_RECOVER;
                    cnt_d   = CNT_W'(RECOVER_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HPI_RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = HPI_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = HPI_IDLE;
            end
        endcase
    end

    // Pin values are decoded from the next state so that the registered
    // outputs line up with the state they belong to.
    always_comb begin
        busNext = (state_d == HPI_SETUP) || (state_d == HPI_STROBE) || (state_d == HPI_HOLD);
        csN_d   = ~busNext;
        rdN_d   = ~((state_d == HPI_STROBE) && !isWrite_d);
        wrN_d   = ~((state_d == HPI_STROBE) && isWrite_d);
        oe_d    = busNext && isWrite_d;
    end

    // State and output registers; reset drops every strobe at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= HPI_IDLE;
            cnt_q      <= '0;
            isWrite_q  <= 1'b0;
            addr_q     <= '0;
            dataOut_q  <= '0;
            readData_q <= '0;
            csN_q      <= 1'b1;
            rdN_q      <= 1'b1;
            wrN_q      <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            isWrite_q  <= isWrite_d;
            addr_q     <= addr_d;
            dataOut_q  <= dataOut_d;
            readData_q <= readData_d;
            csN_q      <= csN_d;
            rdN_q      <= rdN_d;
            wrN_q      <= wrN_d;
            oe_q       <= oe_d;
        end
    end

    assign readdata         = readData_q;
    assign otg_hpi_addr     = addr_q;
    assign otg_hpi_cs_n     = csN_q;
    assign otg_hpi_r_n      = rdN_q;
    assign otg_hpi_w_n      = wrN_q;
    assign otg_hpi_data_out = dataOut_q;
    assign otg_hpi_data_oe  = oe_q;

endmodule

// File: tb/tb_final2_soc_otg_hpi_bridge.sv
// Scoreboard bench for the OTG HPI bridge. A driver issues Avalon accesses
// and queues the expected transaction; a monitor watches the HPI pins each
// cycle and, on every ack, checks the transaction against a cycle-budget
// model (setup + strobe + hold until ack, recovery before the next accept).
module tb_final2_soc_otg_hpi_bridge;
    import final2_soc_otg_hpi_pkg::*;

    localparam int P_SETUP   = DEF_SETUP_CYC;
    localparam int P_STROBE  = DEF_STROBE_CYC;
    localparam int P_HOLD    = DEF_HOLD_CYC;
    localparam int P_RECOVER = DEF_RECOVER_CYC;
    // Cycles from the accepting IDLE cycle to the ack (last HOLD) cycle.
    localparam int ACK_OFS   = P_SETUP + P_STROBE + P_HOLD;

    localparam int Q_SETUP   = 2;
    localparam int Q_STROBE  = 1;
    localparam int Q_HOLD    = 3;
    localparam int Q_RECOVER = 1;

    typedef struct {
        bit          isWrite;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] pad;
        int          start;
    } txn_t;

    logic        clk, reset_n;
    logic [1:0]  address;
    logic        chipselect, read_n, write_n;
    logic [15:0] writedata, readdata, otg_hpi_data_out, otg_hpi_data_in;
    logic        waitrequest, otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_data_oe;
    logic [1:0]  otg_hpi_addr;

    logic        cs2, rd2N, wr2N, wait2, cs2N, r2N, w2N, oe2;
    logic [1:0]  addr2, hpiAddr2;
    logic [15:0] wd2, rdata2, dout2, din2;

    txn_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    int          nextAccept = -100;
    logic [15:0] lastRead = 16'h0;
    bit          trackActive = 0;
    int          csLow = 0, rLow = 0, wLow = 0, oeHigh = 0, addrBad = 0, dataBad = 0;

    final2_soc_otg_hpi_bridge dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .otg_hpi_addr(otg_hpi_addr), .otg_hpi_cs_n(otg_hpi_cs_n),
        .otg_hpi_r_n(otg_hpi_r_n), .otg_hpi_w_n(otg_hpi_w_n),
        .otg_hpi_data_out(otg_hpi_data_out), .otg_hpi_data_oe(otg_hpi_data_oe),
        .otg_hpi_data_in(otg_hpi_data_in)
    );

    final2_soc_otg_hpi_bridge #(
        .SETUP_CYC(Q_SETUP), .STROBE_CYC(Q_STROBE), .HOLD_CYC(Q_HOLD), .RECOVER_CYC(Q_RECOVER)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .address(addr2), .chipselect(cs2),
        .read_n(rd2N), .write_n(wr2N), .writedata(wd2), .readdata(rdata2),
        .waitrequest(wait2), .otg_hpi_addr(hpiAddr2), .otg_hpi_cs_n(cs2N),
        .otg_hpi_r_n(r2N), .otg_hpi_w_n(w2N),
        .otg_hpi_data_out(dout2), .otg_hpi_data_oe(oe2), .otg_hpi_data_in(din2)
    );

    // Free-running clock and a cycle index that the driver and monitor share.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one access after 'gap' idle cycles and hold it until acked.
    // kind: 0 read, 1 write, 2 read_n and write_n both low (a write).
    task automatic applyStimulus(input int kind, input logic [1:0] a, input logic [15:0] wd,
                                 input logic [15:0] pad, input int gap);
        txn_t t;
        bit   got;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        trackActive     = 1'b1;
        otg_hpi_data_in = pad;
        address         = a;
        writedata       = wd;
        read_n          = (kind == 1);
        write_n         = (kind == 0);
        chipselect      = 1'b1;
        t.isWrite = (kind != 0);
        t.addr    = a;
        t.wdata   = wd;
        t.pad     = pad;
        t.start   = cycle;
        expQ.push_back(t);
        got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!waitrequest) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL ack_timeout: got no ack required ack within 60 cycles");
            expQ.delete();
        end
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
    endtask

    // Monitor: tallies pin activity per transaction and checks it at the ack.
    initial begin
        txn_t t;
        int   accept, expAck;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                csLow = 0; rLow = 0; wLow = 0; oeHigh = 0; addrBad = 0; dataBad = 0;
            end else begin
                if (trackActive) begin
                    if (!otg_hpi_cs_n) csLow++;
                    if (!otg_hpi_r_n)  rLow++;
                    if (!otg_hpi_w_n)  wLow++;
                    if (otg_hpi_data_oe) oeHigh++;
                    if (expQ.size() > 0) begin
                        if (!otg_hpi_cs_n && otg_hpi_addr !== expQ[0].addr) addrBad++;
                        if (otg_hpi_data_oe && otg_hpi_data_out !== expQ[0].wdata) dataBad++;
                    end
                end
                if (chipselect && (!read_n || !write_n) && !waitrequest) begin
                    if (expQ.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("[TB] FAIL unexpected_ack: got ack in cycle %0d required none", cycle);
                    end else begin
                        t = expQ.pop_front();
                        accept = (t.start > nextAccept) ? t.start : nextAccept;
                        expAck = accept + ACK_OFS;
                        nextAccept = expAck + P_RECOVER + 1;
                        checkOutput("ack_cycle",   32'(cycle),   32'(expAck));
                        checkOutput("cs_low_cycles", 32'(csLow), 32'(P_SETUP + P_STROBE + P_HOLD));
                        checkOutput("r_low_cycles",  32'(rLow),  t.isWrite ? 32'd0 : 32'(P_STROBE));
                        checkOutput("w_low_cycles",  32'(wLow),  t.isWrite ? 32'(P_STROBE) : 32'd0);
                        checkOutput("oe_cycles",     32'(oeHigh),
                                    t.isWrite ? 32'(P_SETUP + P_STROBE + P_HOLD) : 32'd0);
                        checkOutput("addr_pin_errs", 32'(addrBad), 32'd0);
                        checkOutput("data_pin_errs", 32'(dataBad), 32'd0);
                        checkOutput("addr_pin",      32'(otg_hpi_addr), 32'(t.addr));
                        checkOutput("readdata",      32'(readdata),
                                    t.isWrite ? 32'(lastRead) : 32'(t.pad));
                        if (!t.isWrite) lastRead = t.pad;
                    end
                    csLow = 0; rLow = 0; wLow = 0; oeHigh = 0; addrBad = 0; dataBad = 0;
                end
            end
        end
    end

    // Second instance with non-default timing: hold a write request for two
    // back-to-back transfers and record ack cycles and chip-select falls.
    task automatic runParamTest();
        int acks[$];
        int falls[$];
        logic prevCs;
        int  expAck2, expAccept2;
        expAck2    = Q_SETUP + Q_STROBE + Q_HOLD;
        expAccept2 = expAck2 + Q_RECOVER + 1;
        prevCs = 1'b1;
        addr2 = HPI_REG_MAILBOX;
        wd2   = 16'h3C3C;
        cs2   = 1'b1;
        wr2N  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!wait2) acks.push_back(c);
            if (prevCs && !cs2N) falls.push_back(c);
            prevCs = cs2N;
        end
        @(posedge clk);
        #1;
        cs2  = 1'b0;
        wr2N = 1'b1;
        checkOutput("p2_ack_count", 32'(acks.size()), 32'd2);
        checkOutput("p2_first_ack", (acks.size() > 0) ? 32'(acks[0]) : 32'hFFFF, 32'(expAck2));
        checkOutput("p2_second_ack", (acks.size() > 1) ? 32'(acks[1]) : 32'hFFFF,
                    32'(expAccept2 + expAck2));
        checkOutput("p2_first_setup", (falls.size() > 0) ? 32'(falls[0]) : 32'hFFFF, 32'd1);
        checkOutput("p2_second_setup", (falls.size() > 1) ? 32'(falls[1]) : 32'hFFFF,
                    32'(expAccept2 + 1));
    endtask

    initial begin
        int          kind, gap;
        logic [1:0]  a;
        logic [15:0] wd, pad;
        reset_n = 1'b0;
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = 2'd0; writedata = 16'h0; otg_hpi_data_in = 16'h0;
        cs2 = 1'b0; rd2N = 1'b1; wr2N = 1'b1; addr2 = 2'd0; wd2 = 16'h0; din2 = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cs_n",     32'(otg_hpi_cs_n), 32'd1);
        checkOutput("rst_r_n",      32'(otg_hpi_r_n),  32'd1);
        checkOutput("rst_w_n",      32'(otg_hpi_w_n),  32'd1);
        checkOutput("rst_oe",       32'(otg_hpi_data_oe), 32'd0);
        checkOutput("rst_addr",     32'(otg_hpi_addr), 32'd0);
        checkOutput("rst_data_out", 32'(otg_hpi_data_out), 32'd0);
        checkOutput("rst_readdata", 32'(readdata), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed transfers");
        applyStimulus(1, HPI_REG_ADDRESS, 16'h1234, 16'h0000, 0);
        applyStimulus(0, HPI_REG_DATA,    16'h0000, 16'hBEEF, 2);
        applyStimulus(1, HPI_REG_MAILBOX, 16'hA5A5, 16'h0000, 3);
        applyStimulus(1, HPI_REG_MAILBOX, 16'h5AA5, 16'h0000, 0);
        applyStimulus(2, HPI_REG_STATUS,  16'h00FF, 16'h7777, 1);

        $display("[TB] random transfers");
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 2));
            gap  = int'($urandom_range(0, 3));
            a    = 2'($urandom_range(0, 3));
            wd   = 16'($urandom);
            pad  = 16'($urandom);
            applyStimulus(kind, a, wd, pad, gap);
        end

        $display("[TB] reset during strobe");
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        trackActive = 1'b0;
        address     = HPI_REG_ADDRESS;
        writedata   = 16'h5A5A;
        read_n      = 1'b1;
        write_n     = 1'b0;
        chipselect  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_reset_w_n",  32'(otg_hpi_w_n),  32'd0);
        checkOutput("pre_reset_cs_n", 32'(otg_hpi_cs_n), 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_cs_n", 32'(otg_hpi_cs_n), 32'd1);
        checkOutput("async_rst_w_n",  32'(otg_hpi_w_n),  32'd1);
        checkOutput("async_rst_oe",   32'(otg_hpi_data_oe), 32'd0);
        checkOutput("async_rst_data", 32'(otg_hpi_data_out), 32'd0);
        checkOutput("async_rst_rdata", 32'(readdata), 32'd0);
        chipselect = 1'b0;
        write_n    = 1'b1;
        lastRead   = 16'h0;
        nextAccept = -100;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_cs_n", 32'(otg_hpi_cs_n), 32'd1);
        checkOutput("post_reset_wait", 32'(waitrequest), 32'd0);
        applyStimulus(0, HPI_REG_DATA, 16'h0000, 16'hC0DE, 0);

        $display("[TB] alternate timing instance");
        runParamTest();

        for (int i = 0; i < 50 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL drain: got %0d pending required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
